// File: rtl/button_conditioner_pkg.sv
// Shared mode encodings and default timing constants for the push-button front-end.
// Latency: n/a (declarations only); no backpressure.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    MODE_RELEASED = 2'd0,
    MODE_HOLDING  = 2'd1,
    MODE_LONG     = 2'd2
  } mode_e;

  localparam int DEF_CNT_W        = 8;
  localparam int DEF_DB_TICKS     = 4;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 25;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, tick-gated debounce, long-press level and auto-repeat pulse.
// Latency: 2 clk sync + DB_TICKS ticks to level; no backpressure, outputs are free-running.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DB_TICKS);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_TICKS);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  mode_e            mode_q, mode_d;
  logic             rep_q, rep_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      db_q    <= '0;
      hold_q  <= '0;
      mode_q  <= MODE_RELEASED;
      rep_q   <= 1'b0;
    end else begin
      s1_q    <= btn_raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
    end
  end

  // Any cycle where the synced input agrees with the level restarts the debounce run.
  always_comb begin
    level_d = level_q;
    db_d    = db_q;
    if (s2_q == level_q) begin
      db_d = '0;
    end else if (tick_i) begin
      if ((db_q + ONE) == DB_LIM) begin
        level_d = s2_q;
        db_d    = '0;
      end else begin
        db_d = db_q + ONE;
      end
    end
  end

  // Mode follows the registered level, so the rising edge itself is not counted and
  // long-press drops one edge after the level. Repeat is masked by the next level so
  // a pulse never coincides with a released output.
  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    rep_d  = 1'b0;
    if (!level_q) begin
      mode_d = MODE_RELEASED;
      hold_d = '0;
    end else begin
      if (mode_q == MODE_RELEASED) begin
        mode_d = MODE_HOLDING;
      end
      if (tick_i) begin
        case (mode_q)
          MODE_LONG: begin
            if ((hold_q + ONE) == REP_LIM) begin
              rep_d  = level_d;
              hold_d = '0;
            end else begin
              hold_d = hold_q + ONE;
            end
          end
          default: begin
            if ((hold_q + ONE) == LONG_LIM) begin
              mode_d = MODE_LONG;
              rep_d  = level_d;
              hold_d = '0;
            end else begin
              hold_d = hold_q + ONE;
            end
          end
        endcase
      end
    end
  end

  assign level_o  = level_q;
  assign long_o   = (mode_q == MODE_LONG);
  assign repeat_o = rep_q;

endmodule

// File: rtl/button_conditioner.sv
// Watch push-button front-end: N_BTN independent conditioned channels sharing one tick.
// Latency: 2 clk + DB_TICKS ticks from raw change to level; no backpressure.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_long_o,
  output logic [N_BTN-1:0] btn_repeat_o
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .CNT_W        (CNT_W),
      .DB_TICKS     (DB_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .tick_i    (tick_i),
      .btn_raw_i (btn_raw_i[g]),
      .level_o   (btn_level_o[g]),
      .long_o    (btn_long_o[g]),
      .repeat_o  (btn_repeat_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed test-plan steps followed by random stimulus, checked against a tick-counting model.
module tb_button_conditioner;

  localparam int N   = 4;
  localparam int DB  = 3;
  localparam int LNG = 5;
  localparam int REP = 2;

  logic         clk;
  logic         reset;
  logic         tick;
  logic [N-1:0] raw;
  logic [N-1:0] btn_level_o, btn_long_o, btn_repeat_o;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .N_BTN(N), .CNT_W(8), .DB_TICKS(DB), .LONG_TICKS(LNG), .REPEAT_TICKS(REP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .tick_i       (tick),
    .btn_raw_i    (raw),
    .btn_level_o  (btn_level_o),
    .btn_long_o   (btn_long_o),
    .btn_repeat_o (btn_repeat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Model: synced input, run of disagreeing ticks, and ticks held since the level rose.
  bit m_s1[N], m_s2[N], m_lvl[N], m_long[N], m_rep[N];
  int m_dis[N], m_held[N];

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit prev, nl;
      if (reset) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_long[c] = 0; m_rep[c] = 0;
        m_dis[c] = 0; m_held[c] = 0;
      end else begin
        prev = m_lvl[c];
        nl   = prev;
        if (m_s2[c] == prev) m_dis[c] = 0;
        else if (tick) begin
          m_dis[c]++;
          if (m_dis[c] == DB) begin
            nl = m_s2[c];
            m_dis[c] = 0;
          end
        end
        m_rep[c] = 0;
        if (!prev) begin
          m_held[c] = 0;
          m_long[c] = 0;
        end else if (tick) begin
          m_held[c]++;
          m_long[c] = (m_held[c] >= LNG);
          if (m_held[c] >= LNG && ((m_held[c] - LNG) % REP) == 0 && nl) m_rep[c] = 1;
        end
        m_lvl[c] = nl;
        m_s2[c]  = m_s1[c];
        m_s1[c]  = raw[c];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] el, eg, er;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      el[c] = m_lvl[c];
      eg[c] = m_long[c];
      er[c] = m_rep[c];
    end
    check("model_level",  32'(btn_level_o),  32'(el));
    check("model_long",   32'(btn_long_o),   32'(eg));
    check("model_repeat", 32'(btn_repeat_o), 32'(er));
  endtask

  initial begin
    int rise, fall, lfall, long_e, seen, late, flip_div;
    logic [31:0] mask;

    reset = 1'b1; tick = 1'b1; raw = '0;
    repeat (3) step();
    check("reset_outputs", 32'({btn_level_o, btn_long_o, btn_repeat_o}), 32'd0);
    reset = 1'b0;
    repeat (20) step();
    check("idle_outputs", 32'({btn_level_o, btn_long_o, btn_repeat_o}), 32'd0);

    raw[0] = 1'b1; rise = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (rise == 0 && btn_level_o[0]) rise = i;
    end
    check("press_latency", rise, 5);
    check("press_others", 32'(btn_level_o[3:1]), 32'd0);
    raw[0] = 1'b0;
    repeat (12) step();

    seen = 0;
    for (int i = 0; i < 30; i++) begin
      raw[1] = ((i % 3) != 2);
      step();
      if (btn_level_o[1]) seen = 1;
    end
    check("bounce_level", seen, 0);
    raw[1] = 1'b0;
    repeat (6) step();

    raw[2] = 1'b1; rise = 0; long_e = 0; mask = '0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (rise == 0 && btn_level_o[2]) rise = i;
      if (long_e == 0 && btn_long_o[2]) long_e = i;
      if (btn_repeat_o[2]) mask[i] = 1'b1;
    end
    check("long_level_rise", rise, 5);
    check("long_assert", long_e, 10);
    check("repeat_edges", mask, 32'h0001_5400);

    raw[2] = 1'b0; fall = 0; lfall = 0; late = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (fall == 0 && !btn_level_o[2]) fall = i;
      if (lfall == 0 && !btn_long_o[2]) lfall = i;
      if (fall != 0 && btn_repeat_o[2]) late = 1;
    end
    check("release_level", fall, 5);
    check("release_long", lfall, 6);
    check("release_no_repeat", late, 0);

    raw[3] = 1'b1;
    repeat (7) step();
    check("holding_level", 32'(btn_level_o[3]), 32'd1);
    check("holding_long", 32'(btn_long_o[3]), 32'd0);
    reset = 1'b1;
    step();
    check("midpress_reset", 32'({btn_level_o, btn_long_o, btn_repeat_o}), 32'd0);
    reset = 1'b0; rise = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (rise == 0 && btn_level_o[3]) rise = i;
    end
    check("relatch_after_reset", rise, 5);
    raw[3] = 1'b0;
    repeat (10) step();

    raw[0] = 1'b1; rise = 0;
    for (int k = 0; k < 20; k++) begin
      tick = ((k % 4) == 3);
      step();
      if (rise == 0 && btn_level_o[0]) rise = k + 1;
    end
    check("slow_tick_debounce", rise, 12);
    raw[0] = 1'b0; tick = 1'b1;
    repeat (10) step();

    for (int n = 0; n < 3000; n++) begin
      flip_div = (n < 1500) ? 9 : 39;
      reset = ($urandom_range(0, 299) == 0);
      tick  = (n >= 1000 && n < 2000) ? ($urandom_range(0, 2) == 0) : 1'b1;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, flip_div) == 0) raw[c] = ~raw[c];
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
